mux_scan_n: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with two modes: manual select (load-and-hold) and auto-scan (round-robin, fixed dwell per channel).
- Next generation of the team's 4:1 2-bit mux. Adds arbitrary width and channel count, a registered output, a channel-index readback and a timed scan sequencer.
- Used wherever several data sources are time-shared onto one output, for example display or LED channel cycling.

---
 rtl/mux_scan_n.sv | 155 +++++++++++++++
 tb/tb_mux_scan_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - N-channel W-bit registered mux with manual select and timed auto-scan
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   din   - packed channel data, channel k = din[k*W +: W]
//   sel   - channel index applied by load
//   load  - single-cycle request to jump to channel sel (ignored if sel >= N)
//   mode  - 0 = manual hold, 1 = round-robin scan (sampled every cycle)
//   o     - registered data of the channel on ch
//   ch    - registered index of the channel currently on o
//   valid - set by the first legal load, cleared only by reset
//   wrap  - one-cycle pulse when the scan advances from channel N-1 to 0
module mux_scan_n #(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int DWELL = 8,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  din,
    input  logic [SELW-1:0] sel,
    input  logic            load,
    input  logic            mode,
    output logic [W-1:0]    o,
    output logic [SELW-1:0] ch,
    output logic            valid,
    output logic            wrap
);

    localparam int CW = $clog2(DWELL) + 1;

    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    o_q, o_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;

    logic            load_ok;
    logic [W-1:0]    ch_data;

    // Out-of-range selects (only possible when N is not a power of two)
    // are dropped entirely.
    assign load_ok = load && (32'(sel) < N);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_ok) begin
                    ch_d    = sel;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = mode ? SCAN : MANUAL;
                end
            end

            MANUAL: begin
                if (load_ok) begin
                    ch_d = sel;
                end
                if (mode) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end

            SCAN: begin
                if (!mode) begin
                    state_d = MANUAL;
                    cnt_d   = '0;
                    if (load_ok) begin
                        ch_d = sel;
                    end
                end else if (load_ok) begin
                    // Load wins over a dwell advance landing on the same edge.
                    ch_d  = sel;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        ch_d   = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                ch_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Data of the channel ch will hold after this edge, so o and ch stay
    // coherent. Compare-and-select avoids indexing past N-1.
    always_comb begin
        ch_data = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_d == SELW'(k)) begin
                ch_data = din[k*W +: W];
            end
        end
    end

    always_comb begin
        o_d = (state_d == IDLE) ? '0 : ch_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o     = o_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - directed self-checking bench for mux_scan_n
module tb_mux_scan_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: N=4, W=2, DWELL=3
    logic       rst_a;
    logic [7:0] din_a;
    logic [1:0] sel_a;
    logic       load_a;
    logic       mode_a;
    logic [1:0] o_a;
    logic [1:0] ch_a;
    logic       valid_a;
    logic       wrap_a;

    mux_scan_n #(.N(4), .W(2), .DWELL(3)) dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .din   (din_a),
        .sel   (sel_a),
        .load  (load_a),
        .mode  (mode_a),
        .o     (o_a),
        .ch    (ch_a),
        .valid (valid_a),
        .wrap  (wrap_a)
    );

    // Instance B: N=3, W=4, DWELL=1
    logic        rst_b;
    logic [11:0] din_b;
    logic [1:0]  sel_b;
    logic        load_b;
    logic        mode_b;
    logic [3:0]  o_b;
    logic [1:0]  ch_b;
    logic        valid_b;
    logic        wrap_b;

    mux_scan_n #(.N(3), .W(4), .DWELL(1)) dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .din   (din_b),
        .sel   (sel_b),
        .load  (load_b),
        .mode  (mode_b),
        .o     (o_b),
        .ch    (ch_b),
        .valid (valid_b),
        .wrap  (wrap_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [1:0] e_ch, input logic [1:0] e_o,
                           input logic e_valid, input logic e_wrap);
        check({tag, ".ch"},    32'(ch_a),    32'(e_ch));
        check({tag, ".o"},     32'(o_a),     32'(e_o));
        check({tag, ".valid"}, 32'(valid_a), 32'(e_valid));
        check({tag, ".wrap"},  32'(wrap_a),  32'(e_wrap));
    endtask

    task automatic check_b(input string tag, input logic [1:0] e_ch, input logic [3:0] e_o,
                           input logic e_valid, input logic e_wrap);
        check({tag, ".ch"},    32'(ch_b),    32'(e_ch));
        check({tag, ".o"},     32'(o_b),     32'(e_o));
        check({tag, ".valid"}, 32'(valid_b), 32'(e_valid));
        check({tag, ".wrap"},  32'(wrap_b),  32'(e_wrap));
    endtask

    initial begin
        // ch3=11 ch2=10 ch1=01 ch0=00
        din_a  = 8'b11_10_01_00;
        sel_a  = 2'd0;
        load_a = 1'b0;
        mode_a = 1'b1;
        rst_a  = 1'b1;
        // ch2=C ch1=B ch0=A
        din_b  = 12'hCBA;
        sel_b  = 2'd0;
        load_b = 1'b0;
        mode_b = 1'b1;
        rst_b  = 1'b1;

        // 1. Reset for 2 cycles, then idle with mode=1 and no load
        step();
        step();
        check_a("reset", 2'd0, 2'b00, 1'b0, 1'b0);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("idle_hold", 2'd0, 2'b00, 1'b0, 1'b0);
        end

        // 2. Manual load sel=2, then change channel 2 data
        mode_a = 1'b0;
        sel_a  = 2'd2;
        load_a = 1'b1;
        step();
        check_a("man_load", 2'd2, 2'b10, 1'b1, 1'b0);
        load_a = 1'b0;
        step();
        check_a("man_hold", 2'd2, 2'b10, 1'b1, 1'b0);
        din_a[5:4] = 2'b01;
        step();
        check_a("man_din", 2'd2, 2'b01, 1'b1, 1'b0);
        din_a[5:4] = 2'b10;
        step();
        check_a("man_restore", 2'd2, 2'b10, 1'b1, 1'b0);

        // 3. Scan from channel 0: each channel held 3 cycles, wrap on 3->0
        mode_a = 1'b1;
        sel_a  = 2'd0;
        load_a = 1'b1;
        step();
        check_a("scan_t0", 2'd0, 2'b00, 1'b1, 1'b0);
        load_a = 1'b0;
        for (int t = 1; t <= 13; t++) begin
            logic [1:0] e;
            e = 2'((t / 3) % 4);
            step();
            check_a($sformatf("scan_t%0d", t), e, e, 1'b1, (t == 12));
        end

        // 4a. Load sel=3 with counter=1 (one cycle after the 3->0 advance)
        sel_a  = 2'd3;
        load_a = 1'b1;
        step();
        check_a("ld_mid", 2'd3, 2'b11, 1'b1, 1'b0);
        load_a = 1'b0;
        step();
        check_a("ld_mid_h1", 2'd3, 2'b11, 1'b1, 1'b0);
        step();
        check_a("ld_mid_h2", 2'd3, 2'b11, 1'b1, 1'b0);
        step();
        check_a("ld_mid_wrap", 2'd0, 2'b00, 1'b1, 1'b1);
        step();
        check_a("ld_mid_c1", 2'd0, 2'b00, 1'b1, 1'b0);
        step();
        check_a("ld_mid_c2", 2'd0, 2'b00, 1'b1, 1'b0);

        // 4b. Load on a dwell-end cycle: ch=sel, no advance
        sel_a  = 2'd2;
        load_a = 1'b1;
        step();
        check_a("ld_end", 2'd2, 2'b10, 1'b1, 1'b0);
        load_a = 1'b0;
        step();
        check_a("ld_end_h1", 2'd2, 2'b10, 1'b1, 1'b0);

        // 6a. Reset in mid-scan at ch=2
        rst_a = 1'b1;
        step();
        check_a("rst_scan", 2'd0, 2'b00, 1'b0, 1'b0);
        rst_a = 1'b0;
        step();
        check_a("rst_idle", 2'd0, 2'b00, 1'b0, 1'b0);

        // 6b. Scan on ch=1, switch to manual: ch holds 1, wrap stays 0
        sel_a  = 2'd1;
        load_a = 1'b1;
        mode_a = 1'b1;
        step();
        check_a("sw_load", 2'd1, 2'b01, 1'b1, 1'b0);
        load_a = 1'b0;
        step();
        mode_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_a($sformatf("sw_hold%0d", i), 2'd1, 2'b01, 1'b1, 1'b0);
        end

        // 5. N=3, W=4, DWELL=1
        step();
        check_b("b_reset", 2'd0, 4'h0, 1'b0, 1'b0);
        rst_b  = 1'b0;
        sel_b  = 2'd3;
        load_b = 1'b1;
        step();
        check_b("b_illegal", 2'd0, 4'h0, 1'b0, 1'b0);
        load_b = 1'b0;
        step();
        check_b("b_illegal_h", 2'd0, 4'h0, 1'b0, 1'b0);
        sel_b  = 2'd2;
        load_b = 1'b1;
        step();
        check_b("b_load2", 2'd2, 4'hC, 1'b1, 1'b0);
        load_b = 1'b0;
        step();
        check_b("b_s0", 2'd0, 4'hA, 1'b1, 1'b1);
        step();
        check_b("b_s1", 2'd1, 4'hB, 1'b1, 1'b0);
        step();
        check_b("b_s2", 2'd2, 4'hC, 1'b1, 1'b0);
        step();
        check_b("b_s3", 2'd0, 4'hA, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
